// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction controller.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DISPENSE,
        ST_RET_ON,
        ST_RET_GAP
    } vend_state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_BAD  = 2'b11;

    localparam int COIN_UNIT_RS = 5;

    // Credit value of a coin code, in COIN_UNIT_RS units; illegal/none count as zero.
    function automatic int coin_units(input logic [1:0] code);
        case (code)
            COIN_5:  return 1;
            COIN_10: return 2;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/vend_pulse_timer.sv
// Loadable down-counter; done is high on the last cycle of a len-cycle interval.
module pulse_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] len,
    output logic         done
);

    logic [W-1:0] tmr;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr <= '0;
        end else if (load) begin
            tmr <= len - W'(1);
        end else if (tmr != '0) begin
            tmr <= tmr - W'(1);
        end
    end

    assign done = (tmr == '0);

endmodule

// File: rtl/vend_sequencer.sv
// Coin credit accumulation and dispense/return pulse sequencing FSM.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int PRICE     = 3,
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 2,
    parameter int CW        = $clog2(PRICE + 2)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    in,
    input  logic          cancel,
    output logic          dispense,
    output logic          coin_ret,
    output logic          reject,
    output logic          busy,
    output logic [CW-1:0] credit
);

    localparam int TMAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int TW   = $clog2(TMAX + 1);

    vend_state_t   state, state_d;
    logic [CW-1:0] chg, chg_d, credit_d, nc;
    logic          reject_d;
    logic          tmr_load, tmr_done;
    logic [TW-1:0] tmr_len;

    pulse_timer #(.W(TW)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (tmr_load),
        .len  (tmr_len),
        .done (tmr_done)
    );

    assign nc = credit + CW'(coin_units(in));

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d  = state;
        credit_d = credit;
        chg_d    = chg;
        reject_d = 1'b0;
        tmr_load = 1'b0;
        tmr_len  = TW'(PULSE_LEN);
        case (state)
            ST_IDLE, ST_COLLECT: begin
                if (state == ST_COLLECT && cancel) begin
                    // Cancel wins over a simultaneous coin, which is bounced.
                    chg_d    = credit;
                    credit_d = '0;
                    reject_d = (in != COIN_NONE);
                    state_d  = ST_RET_ON;
                    tmr_load = 1'b1;
                end else if (in == COIN_BAD) begin
                    reject_d = 1'b1;
                end else if (in != COIN_NONE) begin
                    if (nc >= CW'(PRICE)) begin
                        chg_d    = nc - CW'(PRICE);
                        credit_d = '0;
                        state_d  = ST_DISPENSE;
                        tmr_load = 1'b1;
                    end else begin
                        credit_d = nc;
                        state_d  = ST_COLLECT;
                    end
                end
            end
            ST_DISPENSE: begin
                reject_d = (in != COIN_NONE);
                if (tmr_done) begin
                    if (chg != '0) begin
                        state_d  = ST_RET_ON;
                        tmr_load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RET_ON: begin
                reject_d = (in != COIN_NONE);
                if (tmr_done) begin
                    chg_d    = chg - CW'(1);
                    state_d  = ST_RET_GAP;
                    tmr_load = 1'b1;
                    tmr_len  = TW'(GAP_LEN);
                end
            end
            ST_RET_GAP: begin
                reject_d = (in != COIN_NONE);
                if (tmr_done) begin
                    if (chg != '0) begin
                        state_d  = ST_RET_ON;
                        tmr_load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so each one leaves a flop directly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            credit   <= '0;
            chg      <= '0;
            reject   <= 1'b0;
            dispense <= 1'b0;
            coin_ret <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_d;
            credit   <= credit_d;
            chg      <= chg_d;
            reject   <= reject_d;
            dispense <= (state_d == ST_DISPENSE);
            coin_ret <= (state_d == ST_RET_ON);
            busy     <= (state_d == ST_DISPENSE) || (state_d == ST_RET_ON) ||
                        (state_d == ST_RET_GAP);
        end
    end

endmodule

// File: tb/tb_vend_sequencer.sv
// Scoreboard bench for vend_sequencer: expected output frames are queued per driven cycle.
module tb_vend_sequencer;

    localparam int PRICE = 3;
    localparam int P     = 4;
    localparam int G     = 2;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [1:0]    in = 2'b00;
    logic          cancel = 1'b0;
    logic          dispense, coin_ret, reject, busy;
    logic [CW-1:0] credit;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] exp_q[$];

    vend_sequencer #(.PRICE(PRICE), .PULSE_LEN(P), .GAP_LEN(G)) dut (
        .clk      (clk),
        .rst      (rst),
        .in       (in),
        .cancel   (cancel),
        .dispense (dispense),
        .coin_ret (coin_ret),
        .reject   (reject),
        .busy     (busy),
        .credit   (credit)
    );

    always #5 clk = ~clk;

    // Frame layout: {dispense, coin_ret, reject, busy, credit[2:0]}
    function automatic logic [6:0] mk(input bit d, input bit r, input bit j, input bit b,
                                      input int cr);
        return {d, r, j, b, 3'(cr)};
    endfunction

    function automatic logic [6:0] frame_now();
        return {dispense, coin_ret, reject, busy, credit};
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Drive one cycle of inputs, queue the frame expected after the edge, then compare.
    task automatic step(input string tag, input logic [1:0] c, input bit can,
                        input logic [6:0] want);
        logic [6:0] e;
        in     = c;
        cancel = can;
        exp_q.push_back(want);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(tag, {9'd0, frame_now()}, {9'd0, e});
    endtask

    task automatic do_reset();
        in     = 2'b00;
        cancel = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset", {9'd0, frame_now()}, 16'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Busy sequence from the spec's timing: optional dispense, then k return pulses with gaps.
    task automatic run_seq(input string tag, input logic [1:0] c0, input bit can0,
                           input bit rej0, input bit disp, input int k, input int inj_at);
        logic [6:0] f[$];
        if (disp) repeat (P) f.push_back(mk(1, 0, 0, 1, 0));
        repeat (k) begin
            repeat (P) f.push_back(mk(0, 1, 0, 1, 0));
            repeat (G) f.push_back(mk(0, 0, 0, 1, 0));
        end
        f.push_back(mk(0, 0, 0, 0, 0));
        if (rej0) f[0][4] = 1'b1;
        if (inj_at > 0) f[inj_at][4] = 1'b1;
        for (int i = 0; i < f.size(); i++) begin
            if (i == 0)           step(tag, c0, can0, f[i]);
            else if (i == inj_at) step(tag, 2'b01, 1'b0, f[i]);
            else                  step(tag, 2'b00, 1'b0, f[i]);
        end
    endtask

    initial begin
        rst = 1'b0;
        #2;
        check("reset_init", {9'd0, frame_now()}, 16'd0);
        @(negedge clk);
        rst = 1'b1;

        // Three 5 Rs coins: exact price, no change.
        step("c5_1", 2'b01, 1'b0, mk(0, 0, 0, 0, 1));
        step("idle_1", 2'b00, 1'b0, mk(0, 0, 0, 0, 1));
        step("c5_2", 2'b01, 1'b0, mk(0, 0, 0, 0, 2));
        step("idle_2", 2'b00, 1'b0, mk(0, 0, 0, 0, 2));
        run_seq("buy_exact", 2'b01, 1'b0, 1'b0, 1'b1, 0, -1);

        // Two 10 Rs coins: one unit of change, busy for 10 cycles.
        do_reset();
        step("c10_1", 2'b10, 1'b0, mk(0, 0, 0, 0, 2));
        run_seq("buy_change", 2'b10, 1'b0, 1'b0, 1'b1, 1, -1);

        // Cancel refunds of one and two units.
        step("c5_ref", 2'b01, 1'b0, mk(0, 0, 0, 0, 1));
        run_seq("cancel_1", 2'b00, 1'b1, 1'b0, 1'b0, 1, -1);
        step("c10_ref", 2'b10, 1'b0, mk(0, 0, 0, 0, 2));
        run_seq("cancel_2", 2'b00, 1'b1, 1'b0, 1'b0, 2, -1);

        // Cancel while IDLE does nothing.
        step("cancel_idle", 2'b00, 1'b1, mk(0, 0, 0, 0, 0));

        // Coin during DISPENSE is rejected.
        step("c5_busy", 2'b01, 1'b0, mk(0, 0, 0, 0, 1));
        run_seq("rej_dispense", 2'b10, 1'b0, 1'b0, 1'b1, 0, 1);

        // Illegal code in COLLECT: one-cycle reject, credit held.
        step("c5_bad", 2'b01, 1'b0, mk(0, 0, 0, 0, 1));
        step("bad_code", 2'b11, 1'b0, mk(0, 0, 1, 0, 1));
        step("bad_after", 2'b00, 1'b0, mk(0, 0, 0, 0, 1));

        // Cancel and a 10 Rs coin together: cancel wins, coin bounced.
        run_seq("cancel_coin", 2'b10, 1'b1, 1'b1, 1'b0, 1, -1);

        // Coin accepted again on first IDLE cycle after a purchase.
        step("c10_b2b", 2'b10, 1'b0, mk(0, 0, 0, 0, 2));
        run_seq("b2b_buy", 2'b01, 1'b0, 1'b0, 1'b1, 0, -1);
        step("b2b_next", 2'b01, 1'b0, mk(0, 0, 0, 0, 1));

        // Reset during the second coin_ret cycle drops everything asynchronously.
        step("rr_c1", 2'b00, 1'b1, mk(0, 1, 0, 1, 0));
        step("rr_c2", 2'b00, 1'b0, mk(0, 1, 0, 1, 0));
        #2;
        rst = 1'b0;
        #1;
        check("async_rst", {9'd0, frame_now()}, 16'd0);
        @(negedge clk);
        rst = 1'b1;
        step("post_rst", 2'b00, 1'b0, mk(0, 0, 0, 0, 0));
        step("post_rst_coin", 2'b01, 1'b0, mk(0, 0, 0, 0, 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
